// File: rtl/filter_pkg.sv
// Shared definitions for the filter loader, its scratchpad and the filter consumer.
package filter_pkg;

  localparam int FILTER_WIDTH_DEF = 16;
  localparam int FILTER_ROW_DEF   = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

  // Requested word count clamped to the scratchpad depth.
  function automatic int sat_size(input int req, input int max_rows);
    return (req > max_rows) ? max_rows : req;
  endfunction

endpackage

// File: rtl/filter_loader_if.sv
// Valid/ready word stream feeding the filter loader from upstream.
interface filter_loader_if
  import filter_pkg::*;
#(
  parameter int WIDTH = FILTER_WIDTH_DEF
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/filter_loader_row_counter.sv
// Row counter for the filter loader: synchronous clear, count enable and
// terminal-count flag against the latched load size.
module row_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] size,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_d, count_q;

  always_comb begin
    // NOTE: assign the default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  // Only meaningful while loading, where size is at least one.
  assign terminal = (count_q == size - CW'(1));

endmodule

// File: rtl/filter_loader.sv
// Filter loader: accepts a start request with a word count, streams that many
// words into the scratchpad write port, then holds the filter until released.
module filter_loader
  import filter_pkg::*;
#(
  parameter int FILTER_WIDTH = FILTER_WIDTH_DEF,
  parameter int FILTER_ROW   = FILTER_ROW_DEF,
  localparam int SW          = $clog2(FILTER_ROW + 1),
  localparam int AW          = $clog2(FILTER_ROW)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SW-1:0]           filter_size,
  filter_loader_if.slave          in_if,
  output logic [FILTER_WIDTH-1:0] spad_din,
  output logic [AW-1:0]           spad_waddr,
  output logic                    spad_wen,
  output logic                    spad_chip_en,
  // "release" is a reserved word, hence the prefix.
  input  logic                    filter_release,
  output logic                    busy,
  output logic                    done
);

  state_e                  state_d, state_q;
  logic [SW-1:0]           size_d, size_q;
  logic [SW-1:0]           size_eff;
  logic                    spad_wen_d, spad_wen_q;
  logic [AW-1:0]           spad_waddr_d, spad_waddr_q;
  logic [FILTER_WIDTH-1:0] spad_din_d, spad_din_q;

  logic          in_ready;
  logic          xfer;
  logic          accept_start;
  logic          cnt_clear;
  logic          terminal;
  logic [SW-1:0] count;

  assign size_eff = SW'(sat_size(int'(filter_size), FILTER_ROW));
  assign in_ready = (state_q == ST_LOAD);
  assign xfer     = in_if.in_valid && in_ready;

  row_counter #(
    .CW (SW)
  ) u_row_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (xfer),
    .size     (size_q),
    .count    (count),
    .terminal (terminal)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    accept_start = 1'b0;
    cnt_clear    = 1'b0;

    case (state_q)
      ST_IDLE:  accept_start = start;
      ST_LOAD:  if (xfer && terminal) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_FULL;
      ST_FULL: begin
        if (filter_release) begin
          if (start) accept_start = 1'b1;
          else       state_d      = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    // A zero-length filter skips LOAD but still passes through DRAIN.
    if (accept_start) begin
      size_d    = size_eff;
      cnt_clear = 1'b1;
      state_d   = (size_eff == '0) ? ST_DRAIN : ST_LOAD;
    end
  end

  always_comb begin
    spad_wen_d   = xfer;
    spad_waddr_d = spad_waddr_q;
    spad_din_d   = spad_din_q;
    if (xfer) begin
      spad_waddr_d = count[AW-1:0];
      spad_din_d   = in_if.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the write-port data/address flops are reset as well, so the scratchpad never sees X after reset.
    if (!rst) begin
      state_q      <= ST_IDLE;
      size_q       <= '0;
      spad_wen_q   <= 1'b0;
      spad_waddr_q <= '0;
      spad_din_q   <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      spad_wen_q   <= spad_wen_d;
      spad_waddr_q <= spad_waddr_d;
      spad_din_q   <= spad_din_d;
    end
  end

  assign in_if.in_ready = in_ready;
  assign spad_wen       = spad_wen_q;
  assign spad_waddr     = spad_waddr_q;
  assign spad_din       = spad_din_q;
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign spad_chip_en   = busy;
  assign done           = (state_q == ST_FULL);

endmodule

// File: tb/tb_filter_loader.sv
// Bench for filter_loader: directed scenarios with random data and valid
// patterns, checked against a word-list model of the scratchpad.
module tb_filter_loader;

  localparam int W   = 16;
  localparam int ROW = 12;
  localparam int SW  = $clog2(ROW + 1);
  localparam int AW  = $clog2(ROW);

  logic          clk;
  logic          rst;
  logic          start;
  logic [SW-1:0] filter_size;
  logic          filter_release;
  logic [W-1:0]  spad_din;
  logic [AW-1:0] spad_waddr;
  logic          spad_wen;
  logic          spad_chip_en;
  logic          busy;
  logic          done;

  filter_loader_if #(.WIDTH(W)) in_if ();

  filter_loader #(
    .FILTER_WIDTH (W),
    .FILTER_ROW   (ROW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .filter_size    (filter_size),
    .in_if          (in_if),
    .spad_din       (spad_din),
    .spad_waddr     (spad_waddr),
    .spad_wen       (spad_wen),
    .spad_chip_en   (spad_chip_en),
    .filter_release (filter_release),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Scratchpad model: captures every write the loader issues.
  logic [W-1:0] tb_mem [0:15];
  int           wr_cnt   = 0;
  int           max_addr = 0;

  always @(posedge clk) begin
    if (spad_wen === 1'b1) begin
      tb_mem[int'(spad_waddr)] = spad_din;
      wr_cnt++;
      if (int'(spad_waddr) > max_addr) max_addr = int'(spad_waddr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   busy,           1'b0);
    check({tag, "_done"},   done,           1'b0);
    check({tag, "_ready"},  in_if.in_ready, 1'b0);
    check({tag, "_chipen"}, spad_chip_en,   1'b0);
    check({tag, "_wen"},    spad_wen,       1'b0);
  endtask

  // One complete load. mode 0: valid always high, 1: valid toggling 1/0,
  // 2: random valid plus random start/release that must be ignored.
  task automatic run_load(input int sz, input int mode, input bit from_full);
    int           eff;
    int           acc;
    int           guard;
    int           wr0;
    bit           v;
    logic [W-1:0] d;
    logic [W-1:0] exp_words [ROW];

    eff = (sz > ROW) ? ROW : sz;
    wr0 = wr_cnt;

    start          = 1'b1;
    filter_size    = SW'(sz);
    filter_release = from_full;
    in_if.in_valid = 1'b0;
    step();
    start          = 1'b0;
    filter_release = 1'b0;

    if (eff == 0) begin
      check("zero_busy",   busy,           1'b1);
      check("zero_ready",  in_if.in_ready, 1'b0);
      check("zero_done0",  done,           1'b0);
      step();
      check("zero_done",   done,           1'b1);
      check("zero_writes", wr_cnt - wr0,   0);
      return;
    end

    check("load_ready", in_if.in_ready, 1'b1);
    check("load_busy",  busy,           1'b1);
    check("load_chip",  spad_chip_en,   1'b1);
    check("load_done",  done,           1'b0);

    acc   = 0;
    guard = 0;
    while (acc < eff && guard < 300) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'(($urandom_range(0, 1)));
      endcase
      d              = W'($urandom);
      in_if.in_valid = v;
      in_if.in_data  = d;
      if (mode == 2) begin
        start          = 1'(($urandom_range(0, 1)));
        filter_size    = SW'($urandom_range(1, 3));
        filter_release = 1'(($urandom_range(0, 1)));
      end
      step();
      guard++;
      if (v) begin
        check("beat_wen",   spad_wen,   1'b1);
        check("beat_waddr", spad_waddr, acc);
        check("beat_din",   spad_din,   d);
        exp_words[acc] = d;
        acc++;
      end else begin
        check("gap_wen", spad_wen, 1'b0);
      end
      if (acc < eff) check("still_loading", in_if.in_ready, 1'b1);
    end
    check("load_beats", acc, eff);

    in_if.in_valid = 1'b0;
    start          = 1'b0;
    filter_release = 1'b0;

    check("drain_ready", in_if.in_ready, 1'b0);
    check("drain_busy",  busy,           1'b1);
    check("drain_done",  done,           1'b0);
    step();
    check("full_done",   done,           1'b1);
    check("full_busy",   busy,           1'b0);
    check("full_ready",  in_if.in_ready, 1'b0);
    check("full_wen",    spad_wen,       1'b0);
    check("full_chip",   spad_chip_en,   1'b0);
    check("write_count", wr_cnt - wr0,   eff);
    for (int a = 0; a < eff; a++) begin
      check("spad_word", tb_mem[a], exp_words[a]);
    end
  endtask

  task automatic do_release();
    filter_release = 1'b1;
    step();
    filter_release = 1'b0;
    check_quiet("after_release");
  endtask

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    filter_size    = '0;
    filter_release = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_waddr", spad_waddr, 0);
    check("reset_din",   spad_din,   0);
    rst = 1'b1;
    step();

    // Release and valid in IDLE are ignored.
    filter_release = 1'b1;
    in_if.in_valid = 1'b1;
    step();
    filter_release = 1'b0;
    in_if.in_valid = 1'b0;
    check_quiet("idle_release");
    step();
    check_quiet("idle_hold");

    // Full-depth load with valid held high.
    run_load(12, 0, 1'b0);

    // Start without release in FULL is ignored; done holds.
    start       = 1'b1;
    filter_size = SW'(3);
    step();
    start = 1'b0;
    check("full_start_done",  done,           1'b1);
    check("full_start_ready", in_if.in_ready, 1'b0);
    step();
    check("full_hold_done", done, 1'b1);
    do_release();

    // Toggling valid.
    run_load(4, 1, 1'b0);
    do_release();

    // Oversized request saturates to the scratchpad depth.
    max_addr = 0;
    run_load(15, 2, 1'b0);
    check("max_addr_in_range", (max_addr <= ROW - 1), 1'b1);
    do_release();

    // Zero-length load.
    run_load(0, 0, 1'b0);

    // Back-to-back: release and start together in FULL.
    run_load(3, 0, 1'b1);
    do_release();

    // Random-pattern load with ignored start/release during LOAD.
    run_load(int'($urandom_range(1, ROW)), 2, 1'b0);
    do_release();

    // Reset in the middle of a 12-word load.
    start       = 1'b1;
    filter_size = SW'(12);
    step();
    start          = 1'b0;
    in_if.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_if.in_data = W'($urandom);
      step();
    end
    check("pre_reset_wen", spad_wen, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_waddr", spad_waddr, 0);
    check("async_reset_din",   spad_din,   0);
    in_if.in_valid = 1'b0;
    step();
    #2;
    rst = 1'b1;
    step();
    check_quiet("post_reset_idle");
    run_load(2, 0, 1'b0);
    do_release();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
